// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions used by the modulator and demodulator.
package qpsk_pkg;

    localparam int QPSK_AMP = 16000;

    localparam logic [1:0] SYM_PP = 2'b00;
    localparam logic [1:0] SYM_MP = 2'b01;
    localparam logic [1:0] SYM_MM = 2'b10;
    localparam logic [1:0] SYM_PM = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dds.sv
// Phase-accumulator NCO with parabolic sine shaping; registered sin/cos taps.
module dds (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        fcw,
    output logic signed [15:0] data_sin,
    output logic signed [15:0] data_cos
);

    logic [31:0] phase_q;

    // Half-wave parabola 4x(1-x) approximates sin over each half period
    function automatic logic signed [15:0] parab(input logic [15:0] ph);
        logic [31:0] prod;
        logic [31:0] mag;
        logic signed [15:0] val;
        prod = 32'(ph[14:0]) * (32'd32768 - 32'(ph[14:0]));
        mag  = prod >> 13;
        if (mag > 32'd32767) begin
            mag = 32'd32767;
        end
        val = signed'(16'(mag));
        return ph[15] ? -val : val;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= '0;
            data_sin <= '0;
            data_cos <= '0;
        end else begin
            phase_q  <= phase_q + fcw;
            data_sin <= parab(phase_q[31:16]);
            data_cos <= parab(phase_q[31:16] + 16'h4000);
        end
    end

endmodule

// File: rtl/qpsk_integrate_dump.sv
// One-rail integrate-and-dump: accumulates products, dumps the symbol total on the last sample.
module qpsk_integrate_dump #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned P_W   = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    input  logic signed [P_W-1:0] p_i,
    output logic signed [15:0]    dump_o,
    output logic                  dump_valid_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d, sum_c;
    logic signed [15:0]      dump_q, dump_d;
    logic                    dump_valid_q, dump_valid_d;

    assign sum_c = acc_q + $signed({{(ACC_W-P_W){p_i[P_W-1]}}, p_i});

    always_comb begin
        acc_d        = acc_q;
        dump_d       = dump_q;
        dump_valid_d = 1'b0;
        if (clear_i) begin
            acc_d = '0;
        end else if (valid_i) begin
            if (last_i) begin
                // Last sample is folded into the dumped total, accumulator restarts at zero
                acc_d        = '0;
                dump_d       = sum_c[ACC_W-1 -: 16];
                dump_valid_d = 1'b1;
            end else begin
                acc_d = sum_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            dump_q       <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            dump_q       <= dump_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign dump_o       = dump_q;
    assign dump_valid_o = dump_valid_q;

endmodule

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK receiver: NCO mix, per-symbol integrate-and-dump, hard quadrant decision.
module qpsk_demodulator
    import qpsk_pkg::*;
#(
    parameter int unsigned SYSTEM_CLK_FREQ = 100_000_000,
    parameter int unsigned SYMBOL_RATE     = 1_000_000,
    parameter int unsigned SYMBOL_PERIOD   = SYSTEM_CLK_FREQ / SYMBOL_RATE,
    parameter int unsigned ACC_W           = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        fcw,
    input  logic signed [15:0] rx_sample,
    input  logic               sample_valid,
    input  logic               sym_sync,
    output logic [1:0]         symbol_out,
    output logic               symbol_valid,
    output logic signed [15:0] i_metric,
    output logic signed [15:0] q_metric
);

    localparam int unsigned CNT_W = clog2(SYMBOL_PERIOD);
    localparam int unsigned P_W   = 17;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_PERIOD - 1);

    if (SYMBOL_PERIOD < 2) begin : g_bad_period
        $error("qpsk_demodulator: SYMBOL_PERIOD must be >= 2");
    end
    if (ACC_W < 18 + clog2(SYMBOL_PERIOD)) begin : g_bad_acc_w
        $error("qpsk_demodulator: ACC_W too small for SYMBOL_PERIOD");
    end

    logic signed [15:0] data_sin, data_cos;

    dds u_dds (
        .clk      (clk),
        .reset    (reset),
        .fcw      (fcw),
        .data_sin (data_sin),
        .data_cos (data_cos)
    );

    logic signed [31:0]    prod_i_c, prod_q_c;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [P_W-1:0] pi_q, pi_d, pq_q, pq_d;
    logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;

    assign prod_i_c = 32'(rx_sample) * 32'(data_cos);
    assign prod_q_c = 32'(rx_sample) * 32'(data_sin);

    // Stage 1: mix and count; a sync makes the coincident sample index 0
    always_comb begin
        cnt_d      = cnt_q;
        pi_d       = pi_q;
        pq_d       = pq_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        if (sample_valid) begin
            pi_d = P_W'(prod_i_c >>> 15);
            pq_d = P_W'(-(prod_q_c >>> 15));
        end
        if (sym_sync) begin
            cnt_d      = sample_valid ? CNT_W'(1) : '0;
            s1_valid_d = sample_valid;
        end else if (sample_valid) begin
            s1_valid_d = 1'b1;
            s1_last_d  = (cnt_q == LAST_CNT);
            cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            pi_q       <= '0;
            pq_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pi_q       <= pi_d;
            pq_q       <= pq_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
        end
    end

    logic signed [15:0] dump_i, dump_q;
    logic               dump_valid_i, dump_valid_q;

    qpsk_integrate_dump #(.ACC_W(ACC_W), .P_W(P_W)) u_int_i (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (sym_sync),
        .valid_i      (s1_valid_q),
        .last_i       (s1_last_q),
        .p_i          (pi_q),
        .dump_o       (dump_i),
        .dump_valid_o (dump_valid_i)
    );

    qpsk_integrate_dump #(.ACC_W(ACC_W), .P_W(P_W)) u_int_q (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (sym_sync),
        .valid_i      (s1_valid_q),
        .last_i       (s1_last_q),
        .p_i          (pq_q),
        .dump_o       (dump_q),
        .dump_valid_o (dump_valid_q)
    );

    logic [1:0]         symbol_q, symbol_d;
    logic               sym_valid_q, sym_valid_d;
    logic signed [15:0] i_metric_q, i_metric_d, q_metric_q, q_metric_d;
    logic               dv_c;

    assign dv_c = dump_valid_i & dump_valid_q;

    // Quadrant decision on the dumped totals; zero counts as positive
    always_comb begin
        symbol_d    = symbol_q;
        i_metric_d  = i_metric_q;
        q_metric_d  = q_metric_q;
        sym_valid_d = dv_c;
        if (dv_c) begin
            i_metric_d = dump_i;
            q_metric_d = dump_q;
            case ({~dump_i[15], ~dump_q[15]})
                2'b11:   symbol_d = SYM_PP;
                2'b01:   symbol_d = SYM_MP;
                2'b00:   symbol_d = SYM_MM;
                default: symbol_d = SYM_PM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            symbol_q    <= '0;
            sym_valid_q <= 1'b0;
            i_metric_q  <= '0;
            q_metric_q  <= '0;
        end else begin
            symbol_q    <= symbol_d;
            sym_valid_q <= sym_valid_d;
            i_metric_q  <= i_metric_d;
            q_metric_q  <= q_metric_d;
        end
    end

    assign symbol_out   = symbol_q;
    assign symbol_valid = sym_valid_q;
    assign i_metric     = i_metric_q;
    assign q_metric     = q_metric_q;

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Bench for qpsk_demodulator: symbol-level reference model plus directed latency/sync/gap scenarios.
module tb_qpsk_demodulator;
    import qpsk_pkg::*;

    localparam int unsigned P     = 100;
    localparam int unsigned ACC_W = 32;

    logic               clk;
    logic               reset;
    logic [31:0]        fcw;
    logic signed [15:0] rx_sample;
    logic               sample_valid;
    logic               sym_sync;
    logic [1:0]         symbol_out;
    logic               symbol_valid;
    logic signed [15:0] i_metric;
    logic signed [15:0] q_metric;

    qpsk_demodulator #(
        .SYSTEM_CLK_FREQ (100_000_000),
        .SYMBOL_RATE     (1_000_000),
        .ACC_W           (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fcw          (fcw),
        .rx_sample    (rx_sample),
        .sample_valid (sample_valid),
        .sym_sync     (sym_sync),
        .symbol_out   (symbol_out),
        .symbol_valid (symbol_valid),
        .i_metric     (i_metric),
        .q_metric     (q_metric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     sym_checks = 0;
    longint edge_n = 0;
    longint acc_edge = 0;

    logic signed [15:0] tap_cos = 16'sd0;
    logic signed [15:0] tap_sin = 16'sd0;
    int                 cur_intent = -1;

    typedef struct {
        longint             due;
        logic [1:0]         sym;
        logic signed [15:0] im;
        logic signed [15:0] qm;
        int                 intent;
    } exp_t;

    exp_t   pend[$];
    longint pulse_edges[$];
    longint pulse_im[$];

    int     m_cnt = 0;
    longint m_si = 0;
    longint m_sq = 0;
    int     m_intent = -1;
    bit     m_ok = 1'b0;

    logic [1:0]         e_sym = 2'b00;
    logic signed [15:0] e_im = 16'sd0;
    logic signed [15:0] e_qm = 16'sd0;

    function automatic logic [1:0] decide(input longint si, input longint sq);
        if (si >= 0 && sq >= 0) return SYM_PP;
        if (si < 0 && sq >= 0)  return SYM_MP;
        if (si < 0)             return SYM_MM;
        return SYM_PM;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: symbol totals from plain arithmetic, pulse due two edges after the last sample
    always @(posedge clk) begin : model
        longint pi;
        longint pq;
        exp_t   e;
        bit     ev;
        edge_n++;
        if (!reset) begin
            m_cnt = 0; m_si = 0; m_sq = 0;
            pend.delete();
            e_sym = 2'b00; e_im = 16'sd0; e_qm = 16'sd0;
        end else begin
            if (sym_sync) begin
                for (int k = pend.size() - 1; k >= 0; k--) begin
                    if (pend[k].due == edge_n + 1) pend.delete(k);
                end
                m_cnt = 0; m_si = 0; m_sq = 0;
            end
            if (sample_valid) begin
                pi = (longint'(rx_sample) * longint'(tap_cos)) >>> 15;
                pq = -((longint'(rx_sample) * longint'(tap_sin)) >>> 15);
                if (m_cnt == 0) begin
                    m_intent = cur_intent;
                    m_ok     = 1'b1;
                end
                if (cur_intent != m_intent) m_ok = 1'b0;
                m_si += pi;
                m_sq += pq;
                m_cnt++;
                if (m_cnt == P) begin
                    e.due    = edge_n + 2;
                    e.sym    = decide(m_si, m_sq);
                    e.im     = 16'(m_si >>> (ACC_W - 16));
                    e.qm     = 16'(m_sq >>> (ACC_W - 16));
                    e.intent = m_ok ? m_intent : -1;
                    pend.push_back(e);
                    m_cnt = 0; m_si = 0; m_sq = 0;
                end
            end
        end
        #1;
        ev = (pend.size() > 0 && pend[0].due == edge_n);
        if (ev) begin
            e     = pend.pop_front();
            e_sym = e.sym;
            e_im  = e.im;
            e_qm  = e.qm;
            pulse_edges.push_back(edge_n);
            pulse_im.push_back(longint'(i_metric));
            if (e.intent >= 0) begin
                sym_checks++;
                chk("symbol_vs_sent", longint'(symbol_out), longint'(e.intent));
            end
        end
        chk("symbol_valid", longint'(symbol_valid), longint'(ev));
        chk("symbol_out", longint'(symbol_out), longint'(e_sym));
        chk("i_metric", longint'(i_metric), longint'(e_im));
        chk("q_metric", longint'(q_metric), longint'(e_qm));
    end

    // mode: 0 clean, 1 noisy, 2 zero input
    task automatic drive(input bit v, input bit sync, input int sym, input int mode);
        longint val;
        int     ia;
        int     qa;
        @(negedge clk);
        tap_cos = dut.u_dds.data_cos;
        tap_sin = dut.u_dds.data_sin;
        ia = (sym == 0 || sym == 3) ? QPSK_AMP : -QPSK_AMP;
        qa = (sym == 0 || sym == 1) ? QPSK_AMP : -QPSK_AMP;
        if (mode == 2) val = 0;
        else val = (longint'(ia) * longint'(tap_cos) - longint'(qa) * longint'(tap_sin)) >>> 15;
        if (mode == 1) val += longint'($urandom_range(4000)) - 2000;
        if (val > 32767)  val = 32767;
        if (val < -32768) val = -32768;
        rx_sample    = 16'(val);
        sample_valid = v;
        sym_sync     = sync;
        cur_intent   = sym;
        if (v) acc_edge = edge_n + 1;
    endtask

    task automatic send_symbol(input int sym, input int mode, input bit sync_first,
                               input bit gap, output longint last_edge);
        for (int i = 0; i < int'(P); i++) begin
            drive(1'b1, sync_first && i == 0, sym, mode);
            if (gap) drive(1'b0, 1'b0, sym, mode);
        end
        last_edge = acc_edge;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, -1, 0);
    endtask

    task automatic clear_pulses();
        pulse_edges.delete();
        pulse_im.delete();
    endtask

    initial begin
        longint l0;
        longint l1;
        longint sync_e;
        int     sc0;

        reset        = 1'b0;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        rx_sample    = 16'sd0;
        fcw          = 32'h1999_999A;
        repeat (4) @(negedge clk);
        chk("rst_symbol_out", longint'(symbol_out), 0);
        chk("rst_symbol_valid", longint'(symbol_valid), 0);
        chk("rst_i_metric", longint'(i_metric), 0);
        chk("rst_q_metric", longint'(q_metric), 0);
        reset = 1'b1;
        idle(3);

        // Clean back-to-back symbols 00,01,10,11
        clear_pulses();
        send_symbol(0, 0, 1'b1, 1'b0, l0);
        send_symbol(1, 0, 1'b0, 1'b0, l1);
        send_symbol(2, 0, 1'b0, 1'b0, l1);
        send_symbol(3, 0, 1'b0, 1'b0, l1);
        idle(4);
        chk("clean_pulse_count", longint'(pulse_edges.size()), 4);
        if (pulse_edges.size() == 4) begin
            chk("clean_first_latency", pulse_edges[0] - l0, 2);
            for (int k = 1; k < 4; k++) chk("clean_spacing", pulse_edges[k] - pulse_edges[k-1], 100);
            chk("clean_imetric_pos", longint'(pulse_im[0] > 0), 1);
        end

        // Reset mid-symbol, then resync on the first sample
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, 2, 0);
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        @(negedge clk);
        chk("midrst_symbol_valid", longint'(symbol_valid), 0);
        chk("midrst_i_metric", longint'(i_metric), 0);
        chk("midrst_symbol_out", longint'(symbol_out), 0);
        reset = 1'b1;
        clear_pulses();
        send_symbol(3, 0, 1'b1, 1'b0, l0);
        idle(4);
        chk("midrst_pulse_count", longint'(pulse_edges.size()), 1);
        if (pulse_edges.size() == 1) chk("midrst_latency", pulse_edges[0] - l0, 2);

        // Gapped input 1-0-1-0
        clear_pulses();
        send_symbol(1, 0, 1'b1, 1'b1, l0);
        send_symbol(2, 0, 1'b0, 1'b1, l1);
        idle(4);
        chk("gap_pulse_count", longint'(pulse_edges.size()), 2);
        if (pulse_edges.size() == 2) begin
            chk("gap_latency", pulse_edges[0] - l0, 2);
            chk("gap_spacing", pulse_edges[1] - pulse_edges[0], 200);
        end

        // sym_sync on sample 57 discards the partial symbol
        clear_pulses();
        for (int i = 0; i < 57; i++) drive(1'b1, 1'b0, 3, 0);
        sync_e = acc_edge + 1;
        send_symbol(2, 0, 1'b1, 1'b0, l0);
        idle(4);
        chk("sync57_pulse_count", longint'(pulse_edges.size()), 1);
        if (pulse_edges.size() == 1) chk("sync57_latency", pulse_edges[0] - sync_e, 101);

        // sym_sync on the dump edge suppresses that symbol
        clear_pulses();
        send_symbol(3, 0, 1'b1, 1'b0, l0);
        send_symbol(0, 0, 1'b1, 1'b0, l1);
        idle(4);
        chk("dumpsync_pulse_count", longint'(pulse_edges.size()), 1);
        if (pulse_edges.size() == 1) chk("dumpsync_latency", pulse_edges[0] - l1, 2);

        // All-zero symbol decides as (+,+)
        clear_pulses();
        send_symbol(0, 2, 1'b1, 1'b0, l0);
        idle(4);
        chk("zero_pulse_count", longint'(pulse_edges.size()), 1);
        chk("zero_symbol_out", longint'(symbol_out), 0);
        chk("zero_i_metric", longint'(i_metric), 0);
        chk("zero_q_metric", longint'(q_metric), 0);

        // Random noisy symbols
        clear_pulses();
        sc0 = sym_checks;
        for (int s = 0; s < 400; s++) begin
            send_symbol(int'($urandom_range(3)), 1, s == 0, 1'b0, l0);
        end
        idle(4);
        chk("noise_symbols_checked", longint'(sym_checks - sc0), 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
